matmul_engine: RTL
==================

MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 16, element width in bits.
REQ-002 SHALL have parameter GRID_SIZE, default 2, matrix dimension N; legal range 1..8.
REQ-003 SHALL have parameter ADDR_LEN, default 5, scratchpad word-address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-007 SHALL have ports base_a, base_b, base_c  input  ADDR_LEN each  row-major base addresses of A, B, C.
REQ-008 SHALL have port acc  input  1  1 = C += A*B, 0 = C = A*B.
REQ-009 SHALL have ports busy, done  output  1 each  busy = operation in progress; done = one-cycle completion pulse.
REQ-010 SHALL have ports mem_rd_en  output  1, mem_rd_addr  output  ADDR_LEN, mem_rd_data  input  NUM_SIZE  read port, data valid one cycle after mem_rd_en.
REQ-011 SHALL have ports mem_wr_en  output  1, mem_wr_addr  output  ADDR_LEN, mem_wr_data  output  NUM_SIZE  write port, written at the edge where mem_wr_en=1.

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> RUN -> WRITE -> DONE -> IDLE.
REQ-013 IDLE: busy=0; start=1 SHALL latch base_a/b/c and acc, then enter LOAD next edge; start SHALL be ignored in every other state.
REQ-014 LOAD SHALL issue one read per cycle: A[0..N²-1], then B[0..N²-1], then C[0..N²-1] only if acc=1; R = 2N² or 3N² reads; LOAD lasts R+1 cycles (final cycle captures last data).
REQ-015 Element k of a matrix SHALL be at (base + k) mod 2^ADDR_LEN; address wrap is legal.
REQ-016 Captured A SHALL fill west skew lane i (row i, delayed i cycles); B SHALL fill north skew lane j (column j, delayed j cycles); C (acc=1) SHALL preload PE(i,j) accumulators, otherwise accumulators clear to 0.
REQ-017 RUN SHALL last exactly 3N-2 cycles with the PE grid enabled; PE(i,j) SHALL compute sum over k of A[i][k]*B[k][j] plus preload.
REQ-018 Multiply and accumulate SHALL be unsigned modulo 2^NUM_SIZE (product truncated to NUM_SIZE bits, sum wraps).
REQ-019 WRITE SHALL last N² cycles, cycle m writing C[m/N][m mod N] to (base_c + m) mod 2^ADDR_LEN with mem_wr_en=1.
REQ-020 DONE SHALL last one cycle with done=1, busy=1; IDLE follows; start in DONE is ignored.
REQ-021 busy SHALL be 1 in LOAD, RUN, WRITE, DONE; mem_rd_en only in LOAD read cycles; mem_wr_en only in WRITE.
REQ-022 Total: start sampled at edge t, done=1 during cycle t+1+(R+1)+(3N-2)+N²; N=2, acc=0 -> done in cycle t+18.
REQ-023 Overlap of base_c with A/B regions SHALL be legal; all reads precede any write.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, addresses/data 0, skew lanes and accumulators 0, from any state.
REQ-025 Reset mid-operation SHALL suppress all further writes; no partial completion pulse.

Structure
REQ-026 Shared package SHALL hold FSM state enum and defaults NUM_SIZE, GRID_SIZE, ADDR_LEN.
REQ-027 SHALL instantiate one sub-module pe_grid (parametrised N×N MAC array, ce, north/west lanes, flattened result bus).

Verification
REQ-028 N=2, acc=0, A=[1,2,3,4]@0, B=[5,6,7,8]@4, base_c=8 -> mem[8..11]=[19,22,43,50], done in cycle t+18.
REQ-029 Same with acc=1, mem[8..11]=[1,1,1,1] preloaded -> mem[8..11]=[20,23,44,51], done in cycle t+22.
REQ-030 NUM_SIZE=16, A=B=[256,0,0,256] -> C=[0,0,0,0] (wrap); base_a=30 -> A read from 30,31,0,1.
REQ-031 start pulsed during RUN and DONE -> no restart, exactly one done pulse, four writes.
REQ-032 rst asserted in WRITE after first write -> only mem[base_c] written, busy=0 next cycle, new start works.
REQ-033 GRID_SIZE=4, A=identity, B=0..15 -> C=0..15, RUN lasts 10 cycles, WRITE 16 cycles.

Source files
------------

// File: rtl/matmul_engine_pkg.sv
// Shared FSM state type and default dimensions for the matrix-multiply engine.
package matmul_engine_pkg;

    localparam int unsigned DEF_NUM_SIZE  = 16;
    localparam int unsigned DEF_GRID_SIZE = 2;
    localparam int unsigned DEF_ADDR_LEN  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/matmul_engine_pe_grid.sv
// N x N output-stationary systolic MAC array: A flows east, B flows south.
module matmul_engine_pe_grid #(
    parameter int unsigned NUM_SIZE  = 16,
    parameter int unsigned GRID_SIZE = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clr,
    input  logic                                     ce,
    input  logic                                     first,
    input  logic [GRID_SIZE*NUM_SIZE-1:0]            west,
    input  logic [GRID_SIZE*NUM_SIZE-1:0]            north,
    input  logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0]  preload,
    output logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0]  result
);

    localparam int unsigned N = GRID_SIZE;
    localparam int unsigned W = NUM_SIZE;

    logic [W-1:0] a_fwd [N][N];
    logic [W-1:0] b_fwd [N][N];

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int unsigned IDX = gi * N + gj;
            logic [W-1:0] a_in, b_in, a_q, b_q, acc_q, acc_nxt;

            if (gj == 0) begin : g_wedge
                assign a_in = west[gi*W +: W];
            end else begin : g_wpass
                assign a_in = a_fwd[gi][gj-1];
            end

            if (gi == 0) begin : g_nedge
                assign b_in = north[gj*W +: W];
            end else begin : g_npass
                assign b_in = b_fwd[gi-1][gj];
            end

            // First enabled cycle starts from the preload instead of the stale sum.
            assign acc_nxt = (first ? preload[IDX*W +: W] : acc_q) + a_in * b_in;
            // Forward the in-flight sum so the final value is visible at the last RUN edge.
            assign result[IDX*W +: W] = ce ? acc_nxt : acc_q;
            assign a_fwd[gi][gj] = a_q;
            assign b_fwd[gi][gj] = b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (clr) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ce) begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// Scratchpad-fed N x N matrix multiply: load A/B (and C when accumulating),
// run the systolic grid, then write C back row-major.
module matmul_engine
    import matmul_engine_pkg::*;
#(
    parameter int unsigned NUM_SIZE  = DEF_NUM_SIZE,
    parameter int unsigned GRID_SIZE = DEF_GRID_SIZE,
    parameter int unsigned ADDR_LEN  = DEF_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] base_a,
    input  logic [ADDR_LEN-1:0] base_b,
    input  logic [ADDR_LEN-1:0] base_c,
    input  logic                acc,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_LEN-1:0] mem_rd_addr,
    input  logic [NUM_SIZE-1:0] mem_rd_data,
    output logic                mem_wr_en,
    output logic [ADDR_LEN-1:0] mem_wr_addr,
    output logic [NUM_SIZE-1:0] mem_wr_data
);

    localparam int unsigned N        = GRID_SIZE;
    localparam int unsigned W        = NUM_SIZE;
    localparam int unsigned NN       = N * N;
    localparam int unsigned LANE     = 2 * N - 1;
    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW       = (LANE > 1) ? $clog2(LANE) : 1;
    localparam int unsigned PW       = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned CW       = $clog2(3 * NN + 1);
    localparam int unsigned RUN_LAST = 3 * N - 3;

    state_t              state;
    logic [CW-1:0]       cnt, cnt_inc, load_last;
    logic [ADDR_LEN-1:0] base_b_q, base_c_q;
    logic                acc_mode;
    logic [1:0]          cap_m;
    logic [IW-1:0]       cap_i, cap_j;
    logic [PW-1:0]       cap_k;
    logic [LW-1:0]       lane_idx;
    logic [W-1:0]        west_lane  [N][LANE];
    logic [W-1:0]        north_lane [N][LANE];
    logic [W-1:0]        c_pre [NN];
    logic [W-1:0]        res   [NN];
    logic [N*W-1:0]      west_bus, north_bus;
    logic [NN*W-1:0]     pre_bus, res_bus;
    logic                pe_clr, pe_ce, pe_first;

    assign cnt_inc   = cnt + CW'(1);
    assign load_last = acc_mode ? CW'(3 * NN) : CW'(2 * NN);
    assign lane_idx  = LW'(cap_i) + LW'(cap_j);
    assign pe_clr    = (state == ST_LOAD);
    assign pe_ce     = (state == ST_RUN);
    assign pe_first  = pe_ce && (cnt == '0);

    for (genvar g = 0; g < N; g++) begin : g_lanes
        assign west_bus[g*W +: W]  = west_lane[g][0];
        assign north_bus[g*W +: W] = north_lane[g][0];
    end

    for (genvar g = 0; g < NN; g++) begin : g_elems
        assign pre_bus[g*W +: W] = c_pre[g];
        assign res[g]            = res_bus[g*W +: W];
    end

    // Operand staging: element (r,k) lands in lane slot r+k so lane r starts r cycles late.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start)) begin
            cap_m <= '0;
            cap_i <= '0;
            cap_j <= '0;
            cap_k <= '0;
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < LANE; s++) begin
                    west_lane[i][s]  <= '0;
                    north_lane[i][s] <= '0;
                end
            end
            for (int k = 0; k < NN; k++) begin
                c_pre[k] <= '0;
            end
        end else if (state == ST_LOAD && cnt != '0) begin
            unique case (cap_m)
                2'd0:    west_lane[cap_i][lane_idx]  <= mem_rd_data;
                2'd1:    north_lane[cap_j][lane_idx] <= mem_rd_data;
                default: c_pre[cap_k]                <= mem_rd_data;
            endcase
            cap_k <= (cap_k == PW'(NN - 1)) ? '0 : cap_k + PW'(1);
            if (cap_j == IW'(N - 1)) begin
                cap_j <= '0;
                if (cap_i == IW'(N - 1)) begin
                    cap_i <= '0;
                    cap_m <= cap_m + 2'd1;
                end else begin
                    cap_i <= cap_i + IW'(1);
                end
            end else begin
                cap_j <= cap_j + IW'(1);
            end
        end else if (state == ST_RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < LANE - 1; s++) begin
                    west_lane[i][s]  <= west_lane[i][s+1];
                    north_lane[i][s] <= north_lane[i][s+1];
                end
                west_lane[i][LANE-1]  <= '0;
                north_lane[i][LANE-1] <= '0;
            end
        end
    end

    // Sequencer: IDLE -> LOAD -> RUN -> WRITE -> DONE, all memory-side outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            acc_mode    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_LOAD;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        base_b_q    <= base_b;
                        base_c_q    <= base_c;
                        acc_mode    <= acc;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= base_a;
                    end
                end
                ST_LOAD: begin
                    if (cnt == load_last) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt       <= cnt_inc;
                        mem_rd_en <= (cnt_inc < load_last);
                        if (cnt_inc == CW'(NN))
                            mem_rd_addr <= base_b_q;
                        else if (cnt_inc == CW'(2 * NN))
                            mem_rd_addr <= base_c_q;
                        else
                            mem_rd_addr <= mem_rd_addr + ADDR_LEN'(1);
                    end
                end
                ST_RUN: begin
                    if (cnt == CW'(RUN_LAST)) begin
                        state       <= ST_WRITE;
                        cnt         <= '0;
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= base_c_q;
                        mem_wr_data <= res[0];
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_WRITE: begin
                    if (cnt == CW'(NN - 1)) begin
                        state     <= ST_DONE;
                        mem_wr_en <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt         <= cnt_inc;
                        mem_wr_addr <= mem_wr_addr + ADDR_LEN'(1);
                        mem_wr_data <= res[PW'(cnt_inc)];
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    matmul_engine_pe_grid #(
        .NUM_SIZE  (NUM_SIZE),
        .GRID_SIZE (GRID_SIZE)
    ) pe_grid (
        .clk     (clk),
        .rst     (rst),
        .clr     (pe_clr),
        .ce      (pe_ce),
        .first   (pe_first),
        .west    (west_bus),
        .north   (north_bus),
        .preload (pre_bus),
        .result  (res_bus)
    );

endmodule
